// File: rtl/control_pkg.sv
// Shared opcode, control-bit index and control-word definitions for the main decoder.
package control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;

  localparam int REGDST   = 8;
  localparam int ALUSRC   = 7;
  localparam int MEMTOREG = 6;
  localparam int REGWRITE = 5;
  localparam int MEMREAD  = 4;
  localparam int MEMWRITE = 3;
  localparam int BRANCH   = 2;
  localparam int ALUOP1   = 1;
  localparam int ALUOP0   = 0;

  typedef struct packed {
    logic regdst;
    logic alusrc;
    logic memtoreg;
    logic regwrite;
    logic memread;
    logic memwrite;
    logic branch;
    logic aluop1;
    logic aluop0;
  } ctrl_word_t;

  localparam ctrl_word_t CW_NOP   = 9'b000000000;
  localparam ctrl_word_t CW_RTYPE = 9'b100100010;
  localparam ctrl_word_t CW_LW    = 9'b011110000;
  localparam ctrl_word_t CW_SW    = 9'b010001000;
  localparam ctrl_word_t CW_BEQ   = 9'b000000101;
  localparam ctrl_word_t CW_ADDI  = 9'b010100000;

endpackage

// File: rtl/control_if.sv
// Opcode in, registered control word and illegal flag out.
interface control_if #(
  parameter int OPW = 6,
  parameter int CW  = 9
);
  logic [OPW-1:0] opcode;
  logic [CW-1:0]  controls;
  logic           illegal;

  modport master (output opcode, input controls, input illegal);
  modport slave  (input opcode, output controls, output illegal);
endinterface

// File: rtl/control_decode.sv
// Combinational opcode-to-control-word map. Build option ADDI_DECODE_EN adds addi (opcode 8).
module control_decode
  import control_pkg::*;
#(
  parameter int OPW = 6,
  parameter int CW  = 9
) (
  input  logic [OPW-1:0] opcode,
  output logic [CW-1:0]  controls,
  output logic           illegal
);

  ctrl_word_t word;

  always_comb begin
    word    = CW_NOP;
    illegal = 1'b1;
    case (opcode)
      OPW'(OP_RTYPE): begin word = CW_RTYPE; illegal = 1'b0; end
      OPW'(OP_LW):    begin word = CW_LW;    illegal = 1'b0; end
      OPW'(OP_SW):    begin word = CW_SW;    illegal = 1'b0; end
      OPW'(OP_BEQ):   begin word = CW_BEQ;   illegal = 1'b0; end
`ifdef ADDI_DECODE_EN
      OPW'(OP_ADDI):  begin word = CW_ADDI;  illegal = 1'b0; end
`endif
      default: begin
        // undecoded opcodes fall back to the safe NOP word
        word    = CW_NOP;
        illegal = 1'b1;
      end
    endcase
  end

  assign controls = CW'(word);

endmodule

// File: rtl/control.sv
// Main control decoder top: decode plus one-cycle output register with synchronous reset.
module control
  import control_pkg::*;
#(
  parameter int OPW = 6,
  parameter int CW  = 9
) (
  input  logic      clk,
  input  logic      rst,
  control_if.slave  bus
);

  logic [CW-1:0] dec_controls;
  logic          dec_illegal;

  control_decode #(.OPW(OPW), .CW(CW)) u_decode (
    .opcode   (bus.opcode),
    .controls (dec_controls),
    .illegal  (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.controls <= '0;
      bus.illegal  <= 1'b0;
    end else begin
      bus.controls <= dec_controls;
      bus.illegal  <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_control.sv
// Directed testbench for the control decoder; expected words are hand-written constants.
module tb_control;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  control_if #(.OPW(6), .CW(9)) bus ();

  control #(.OPW(6), .CW(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %b want %b", tag, got, want);
    end
  endtask

  // apply opcode/rst between edges, then sample just after the next rising edge
  task automatic step(input logic [5:0] op, input logic r);
    @(negedge clk);
    bus.opcode = op;
    rst        = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] expect_out(input logic [5:0] op);
    case (op)
      6'd0:  return {9'b100100010, 1'b0};
      6'd35: return {9'b011110000, 1'b0};
      6'd43: return {9'b010001000, 1'b0};
      6'd4:  return {9'b000000101, 1'b0};
`ifdef ADDI_DECODE_EN
      6'd8:  return {9'b010100000, 1'b0};
`endif
      default: return {9'b000000000, 1'b1};
    endcase
  endfunction

  function automatic logic [31:0] obs();
    return {22'd0, bus.controls, bus.illegal};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int legal_cnt;
    int bad_illegal;
    int want_legal;
    logic [31:0] want;
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    bus.opcode = 6'd35;

    // reset held two edges with lw present
    step(6'd35, 1'b1);
    check("reset_edge1", obs(), {22'd0, 9'b000000000, 1'b0});
    step(6'd35, 1'b1);
    check("reset_edge2", obs(), {22'd0, 9'b000000000, 1'b0});
    step(6'd35, 1'b0);
    check("release_lw", obs(), {22'd0, 9'b011110000, 1'b0});

    // back-to-back stream, 100 truncated to 6 bits is 36
    step(6'd35, 1'b0); check("seq_lw",   obs(), {22'd0, 9'b011110000, 1'b0});
    step(6'd43, 1'b0); check("seq_sw",   obs(), {22'd0, 9'b010001000, 1'b0});
    step(6'd4,  1'b0); check("seq_beq",  obs(), {22'd0, 9'b000000101, 1'b0});
    step(6'd36, 1'b0); check("seq_ill",  obs(), {22'd0, 9'b000000000, 1'b1});
    step(6'd0,  1'b0); check("seq_rtype", obs(), {22'd0, 9'b100100010, 1'b0});

    // opcode change between edges must not show before the next edge
    @(negedge clk);
    bus.opcode = 6'd4;
    #1;
    check("latency_hold", obs(), {22'd0, 9'b100100010, 1'b0});
    @(posedge clk);
    #1;
    check("latency_update", obs(), {22'd0, 9'b000000101, 1'b0});

    // reset in the middle of a stream
    step(6'd43, 1'b0); check("mid_sw1",   obs(), {22'd0, 9'b010001000, 1'b0});
    step(6'd43, 1'b1); check("mid_rst",   obs(), {22'd0, 9'b000000000, 1'b0});
    step(6'd43, 1'b0); check("mid_sw3",   obs(), {22'd0, 9'b010001000, 1'b0});

    // reset beats an illegal opcode on the same edge
    step(6'd36, 1'b1); check("rst_wins_ill", obs(), {22'd0, 9'b000000000, 1'b0});

    // addi build option
    step(6'd8, 1'b0);
`ifdef ADDI_DECODE_EN
    check("addi", obs(), {22'd0, 9'b010100000, 1'b0});
`else
    check("addi", obs(), {22'd0, 9'b000000000, 1'b1});
`endif

    // exhaustive sweep
    legal_cnt   = 0;
    bad_illegal = 0;
    for (int op = 0; op < 64; op++) begin
      step(6'(op), 1'b0);
      want = {22'd0, expect_out(6'(op))};
      check($sformatf("sweep_op%0d", op), obs(), want);
      if (!bus.illegal) legal_cnt++;
      else if (bus.controls != 9'd0) bad_illegal++;
    end
`ifdef ADDI_DECODE_EN
    want_legal = 5;
`else
    want_legal = 4;
`endif
    check("sweep_legal_count", 32'(legal_cnt), 32'(want_legal));
    check("sweep_illegal_nonzero", 32'(bad_illegal), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
